ds18b20_poll_sched: RTL
=======================

// Module: ds18b20_poll_sched
// PURPOSE
//  Periodic scheduler for dallas18b20Ctrl. Issues start pulses at a fixed rate, enforces
//  DS18B20 conversion time between transactions, detects the scratchpad-read window via
//  readState, latches the 9-bit result, discards the stale power-on reading, flags a dead sensor.
//  Sits between host logic (enable/force) and dallas18b20Ctrl (start/readState/temperature).
// PARAMETERS
//  TICK_DIV    10000  CLK_10MHZ cycles per 1 ms tick (prescaler wraps at TICK_DIV-1)
//  PERIOD_MS   1000   ms between consecutive start pulses (start-to-start)
//  CONV_MS     750    min ms from transaction done to next start (conversion time)
//  XFER_TO_MS  20     ms allowed from start to readState falling edge
//  FAULT_LIMIT 3      consecutive timeouts that assert fault
//  Legal: PERIOD_MS > CONV_MS + XFER_TO_MS; all >= 1
// PORTS
//  CLK_10MHZ        in   1  system clock
//  RST_N            in   1  asynchronous active-low reset
//  enable           in   1  level; 1 = run periodic polling
//  force_req        in   1  pulse; request sample as soon as CONV_MS satisfied
//  ctrl_start       out  1  1-cycle start pulse to dallas18b20Ctrl.start
//  ctrl_read_state  in   1  dallas18b20Ctrl.readState
//  ctrl_temperature in   9  dallas18b20Ctrl.temperature
//  temp_out         out  9  last accepted temperature
//  temp_valid       out  1  1-cycle pulse when temp_out updates
//  temp_fresh       out  1  level; temp_out holds a non-stale sample
//  fault            out  1  level; FAULT_LIMIT consecutive timeouts
//  miss_cnt         out  8  total timeouts, saturates at 255
// BEHAVIOUR
//  Reset: all outputs 0; state STARTUP; primed=0; counters 0; pending force cleared.
//  ms tick: prescaler in every state; two ms counters: since_start, since_done (saturate).
//  States:
//   STARTUP: wait CONV_MS ms (controller has no reset, may be mid-op) -> IDLE.
//   IDLE: enable=1 -> ISSUE. enable=0 -> stay; force_req ignored.
//   ISSUE: ctrl_start=1 one cycle; since_start<=0; seen_rd<=0 -> XFER.
//   XFER: ctrl_read_state 0->1 sets seen_rd; 1->0 with seen_rd = done:
//     latch ctrl_temperature same cycle; since_done<=0; consec_to<=0; -> CONV.
//     primed=0: discard (no temp_valid), primed<=1, temp_fresh stays 0.
//     primed=1: temp_out<=value, temp_valid=1 next cycle, temp_fresh<=1, fault<=0.
//     since_start reaches XFER_TO_MS first: timeout; miss_cnt+1 (sat), consec_to+1;
//     consec_to==FAULT_LIMIT -> fault<=1, temp_fresh<=0, primed<=0; since_done<=0 -> CONV.
//   CONV: wait since_done>=CONV_MS -> WAIT.
//   WAIT: enable=0 -> IDLE. since_start>=PERIOD_MS or force pending -> ISSUE.
//  force_req: captured in any state except IDLE/STARTUP, held until next ISSUE; 2nd
//   force while pending merges. Force in XFER/CONV is served after CONV_MS, never earlier.
//  enable drop mid XFER/CONV: transaction completes, result still published, then IDLE.
//  enable 0->1 after IDLE: primed retained unless fault reset it.
//  Timeout with seen_rd=1 (fall missing) counts as timeout; result not latched.
//  ctrl_temperature sampled only on done cycle; changes elsewhere ignored.
//  RST_N low mid-op: immediate reset values; STARTUP re-entered on release.
// TESTING (bench: TICK_DIV=10, PERIOD_MS=20, CONV_MS=8, XFER_TO_MS=4, FAULT_LIMIT=3)
//  Reset release, enable=1 -> first ctrl_start 80 clk after release; outputs 0 until then.
//  Model readState 1 for 50 clk returning 0x055 then 0x0A3 -> 1st discarded, temp_valid
//   with temp_out=0x0A3; starts spaced exactly 200 clk.
//  Model never raises readState -> miss_cnt 1,2,3; fault=1 after 3rd timeout (40 clk
//   each); then good read -> fault=0 after prime read, next sample temp_valid.
//  force_req 1 clk after done -> ctrl_start exactly 80 clk after done, not at period.
//  enable=0 during readState high -> result still published, no further ctrl_start.
//  RST_N low during XFER -> ctrl_start/temp_*/fault/miss_cnt 0 asynchronously.

Source files
------------

// File: rtl/ds18b20_poll_sched.sv
// ds18b20_poll_sched
//   Periodic poll scheduler in front of a dallas18b20Ctrl instance. It issues
//   start pulses at a fixed start-to-start rate and keeps at least the sensor
//   conversion time between a completed transaction and the next start. A
//   transaction completes when readState rises and then falls; the 9-bit result
//   is latched on that falling edge. The first reading after power-up (or after
//   a fault) is treated as stale and dropped. Too many consecutive transfer
//   timeouts raise fault.
//
// Ports
//   CLK_10MHZ        in   system clock
//   RST_N            in   asynchronous active-low reset
//   enable           in   level, 1 = run periodic polling
//   force_req        in   pulse, request a sample as soon as conversion time allows
//   ctrl_start       out  1-cycle start pulse to dallas18b20Ctrl.start
//   ctrl_read_state  in   dallas18b20Ctrl.readState
//   ctrl_temperature in   [8:0] dallas18b20Ctrl.temperature
//   temp_out         out  [8:0] last accepted temperature
//   temp_valid       out  1-cycle pulse when temp_out updates
//   temp_fresh       out  level, temp_out holds a non-stale sample
//   fault            out  level, FAULT_LIMIT consecutive timeouts seen
//   miss_cnt         out  [7:0] total timeouts, saturating
//
// TICK_DIV must be at least 4 (sub-ms phase seeds below).
module ds18b20_poll_sched #(
  parameter int unsigned TICK_DIV    = 10000,
  parameter int unsigned PERIOD_MS   = 1000,
  parameter int unsigned CONV_MS     = 750,
  parameter int unsigned XFER_TO_MS  = 20,
  parameter int unsigned FAULT_LIMIT = 3
) (
  input  logic       CLK_10MHZ,
  input  logic       RST_N,
  input  logic       enable,
  input  logic       force_req,
  output logic       ctrl_start,
  input  logic       ctrl_read_state,
  input  logic [8:0] ctrl_temperature,
  output logic [8:0] temp_out,
  output logic       temp_valid,
  output logic       temp_fresh,
  output logic       fault,
  output logic [7:0] miss_cnt
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MW = $clog2(PERIOD_MS + 1);
  localparam int unsigned FW = $clog2(FAULT_LIMIT + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  // Each ms counter owns its sub-ms phase, restarted together with the counter,
  // so every interval is exact in clocks instead of jittering against a shared
  // prescaler. The seeds pre-count the state hops that sit between a threshold
  // being reached and ctrl_start going high (STARTUP->IDLE->ISSUE,
  // CONV->WAIT->ISSUE, WAIT->ISSUE), so the nominal ms figure is the distance
  // from the anchoring event to the start pulse.
  localparam logic [PW-1:0] SEED_BOOT  = PW'(2);
  localparam logic [PW-1:0] SEED_DONE  = PW'(3);
  localparam logic [PW-1:0] SEED_START = PW'(2);

  localparam logic [MW-1:0] PERIOD_T = MW'(PERIOD_MS);
  localparam logic [MW-1:0] CONV_T   = MW'(CONV_MS);
  localparam logic [MW-1:0] XFER_T   = MW'(XFER_TO_MS);
  localparam logic [FW-1:0] FLIM     = FW'(FAULT_LIMIT);

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_ISSUE,
    ST_XFER,
    ST_CONV,
    ST_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0] pre_s, pre_d;
  logic [MW-1:0] since_start, since_done;
  logic          tick_s, tick_d;
  logic          rd_q, rd_rise, rd_fall;
  logic          seen_rd;
  logic          primed;
  logic          force_pend;
  logic [FW-1:0] consec_to, consec_nxt;
  logic          done, timeout;

  assign tick_s  = (pre_s == PRE_LAST);
  assign tick_d  = (pre_d == PRE_LAST);
  assign rd_rise = ctrl_read_state & ~rd_q;
  assign rd_fall = ~ctrl_read_state & rd_q;

  always_comb begin
    consec_nxt = consec_to;
    if (consec_to < FLIM) consec_nxt = consec_to + FW'(1);
  end

  always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
    if (!RST_N) state <= ST_STARTUP;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ctrl_start = 1'b0;
    done       = 1'b0;
    timeout    = 1'b0;
    case (state)
      // The controller has no reset of its own and may be mid-conversion.
      ST_STARTUP: if (since_done >= CONV_T) state_nxt = ST_IDLE;
      ST_IDLE:    if (enable) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        ctrl_start = 1'b1;
        state_nxt  = ST_XFER;
      end
      ST_XFER: begin
        if (rd_fall && seen_rd) begin
          done      = 1'b1;
          state_nxt = ST_CONV;
        end else if (since_start >= XFER_T) begin
          timeout   = 1'b1;
          state_nxt = ST_CONV;
        end
      end
      ST_CONV: if (since_done >= CONV_T) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!enable)                                      state_nxt = ST_IDLE;
        else if ((since_start >= PERIOD_T) || force_pend) state_nxt = ST_ISSUE;
      end
      default: state_nxt = ST_STARTUP;
    endcase
  end

  always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
    if (!RST_N) begin
      pre_s       <= '0;
      pre_d       <= SEED_BOOT;
      since_start <= '0;
      since_done  <= '0;
      rd_q        <= 1'b0;
      seen_rd     <= 1'b0;
      primed      <= 1'b0;
      force_pend  <= 1'b0;
      consec_to   <= '0;
      temp_out    <= '0;
      temp_valid  <= 1'b0;
      temp_fresh  <= 1'b0;
      fault       <= 1'b0;
      miss_cnt    <= '0;
    end else begin
      rd_q       <= ctrl_read_state;
      temp_valid <= 1'b0;

      if (state == ST_ISSUE) begin
        pre_s       <= SEED_START;
        since_start <= '0;
      end else begin
        pre_s <= tick_s ? '0 : pre_s + PW'(1);
        if (tick_s && (since_start != '1)) since_start <= since_start + MW'(1);
      end

      if (done || timeout) begin
        pre_d      <= SEED_DONE;
        since_done <= '0;
      end else begin
        pre_d <= tick_d ? '0 : pre_d + PW'(1);
        if (tick_d && (since_done != '1)) since_done <= since_done + MW'(1);
      end

      if (state == ST_ISSUE)                 seen_rd <= 1'b0;
      else if (state == ST_XFER && rd_rise)  seen_rd <= 1'b1;

      // A request landing in the ISSUE cycle itself is kept for the next start.
      if (state == ST_ISSUE)
        force_pend <= force_req;
      else if (force_req && (state != ST_IDLE) && (state != ST_STARTUP))
        force_pend <= 1'b1;

      if (done) begin
        consec_to <= '0;
        fault     <= 1'b0;
        if (primed) begin
          temp_out   <= ctrl_temperature;
          temp_valid <= 1'b1;
          temp_fresh <= 1'b1;
        end else begin
          primed <= 1'b1;
        end
      end

      if (timeout) begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 8'd1;
        consec_to <= consec_nxt;
        if (consec_nxt >= FLIM) begin
          fault      <= 1'b1;
          temp_fresh <= 1'b0;
          primed     <= 1'b0;
        end
      end
    end
  end

endmodule
